// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage multiply/divide unit with HI/LO registers.
// The full result is computed in the launch cycle and parked in pending
// registers; a down-counter models the unit latency and the result is
// committed to HI/LO on the edge the counter expires.
// Optional feature macro: MDU_BUSY_EARLY_EN (busy also asserts in the
// launch cycle itself so a dependent instruction in D stalls immediately).
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        write,
    input  logic        addr,
    input  logic        cancel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_t;

    mdState_t       r_state;
    mdState_t       w_nextState;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;
    logic [31:0]    r_pendHi;
    logic [31:0]    r_pendLo;
    logic           r_pendValid;

    logic           w_launch;
    logic           w_mtWrite;
    logic           w_commit;
    logic [CW-1:0]  w_loadCnt;
    logic           w_unusedOp;

    logic [63:0]    w_mulA;
    logic [63:0]    w_mulB;
    logic [63:0]    w_product;

    logic           w_negA;
    logic           w_negB;
    logic [31:0]    w_absA;
    logic [31:0]    w_absB;
    logic           w_divZero;
    logic [31:0]    w_divisor;
    logic [31:0]    w_uQuot;
    logic [31:0]    w_uRem;
    logic [31:0]    w_quot;
    logic [31:0]    w_rem;

    // op[2] carries no meaning for this unit
    assign w_unusedOp = op[2];

    // A start outranks a same-cycle MT write; cancel masks both
    assign w_launch  = start & ~cancel & (r_state == IDLE);
    assign w_mtWrite = write & ~start & ~cancel & (r_state == IDLE);
    assign w_commit  = (r_state == RUN) && (r_cnt == '0);
    assign w_loadCnt = op[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);

    // Multiply: sign- or zero-extend to 64 bits so one product serves both forms
    assign w_mulA    = op[0] ? {{32{rs_data[31]}}, rs_data} : {32'd0, rs_data};
    assign w_mulB    = op[0] ? {{32{rt_data[31]}}, rt_data} : {32'd0, rt_data};
    assign w_product = w_mulA * w_mulB;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 lands on 0x80000000 naturally.
    assign w_negA    = op[0] & rs_data[31];
    assign w_negB    = op[0] & rt_data[31];
    assign w_absA    = w_negA ? (32'd0 - rs_data) : rs_data;
    assign w_absB    = w_negB ? (32'd0 - rt_data) : rt_data;
    assign w_divZero = (rt_data == 32'd0);
    assign w_divisor = w_divZero ? 32'd1 : w_absB;
    assign w_uQuot   = w_absA / w_divisor;
    assign w_uRem    = w_absA % w_divisor;
    assign w_quot    = (w_negA ^ w_negB) ? (32'd0 - w_uQuot) : w_uQuot;
    assign w_rem     = w_negA ? (32'd0 - w_uRem) : w_uRem;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and busy decode
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
`ifdef MDU_BUSY_EARLY_EN
        busy = busy | w_launch;
`endif
    end

    // Latency counter, pending result capture, and HI/LO commit or MT write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_pendHi    <= 32'd0;
            r_pendLo    <= 32'd0;
            r_pendValid <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else begin
            if (w_launch) begin
                r_cnt       <= w_loadCnt;
                r_pendHi    <= op[1] ? w_rem  : w_product[63:32];
                r_pendLo    <= op[1] ? w_quot : w_product[31:0];
                r_pendValid <= ~(op[1] & w_divZero);
            end else if ((r_state == RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_commit) begin
                if (r_pendValid) begin
                    r_hi <= r_pendHi;
                    r_lo <= r_pendLo;
                end
            end else if (w_mtWrite) begin
                if (addr) begin
                    r_lo <= rs_data;
                end else begin
                    r_hi <= rs_data;
                end
            end
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign rdata = addr ? r_lo : r_hi;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: table-driven vectors, hand-written corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_mdu_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int LIMIT  = 64;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        write;
    logic        addr;
    logic        cancel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [31:0] mHi;
    logic [31:0] mLo;
    logic        startBusy;
    logic [31:0] snapHi;
    logic [31:0] snapLo;

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expCycles;
    } vec_t;

    vec_t vecs[6];

    mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .write(write),
        .addr(addr), .cancel(cancel), .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .rdata(rdata), .hi(hi), .lo(lo)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one op at a negedge and count busy cycles until idle.
    // cancelAt / mtAt (1-based busy cycle, 0=off) inject cancel or an MTHI mid-run.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic withWrite, input int cancelAt, input int mtAt,
                                 output int cycles);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        write = withWrite; addr = 1'b0;
        #1 startBusy = busy;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; write = 1'b0;
        op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
        snapHi = hi; snapLo = lo;
        cycles = 0;
        while (busy && cycles < LIMIT) begin
            cycles++;
            cancel = (cycles == cancelAt);
            write  = (cycles == mtAt);
            addr   = 1'b0;
            if (cycles == mtAt) rs_data = 32'h0000_0055;
            @(negedge clk);
        end
        cancel = 1'b0; write = 1'b0;
    endtask

    task automatic writeReg(input logic a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; addr = a; rs_data = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Reference model: plain integer arithmetic on the architectural rules
    function automatic void modelOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] up;
        longint      sp, sa, sb, q, r;
        case (o[1:0])
            2'b00: begin up = 64'(a) * 64'(b); mHi = up[63:32]; mLo = up[31:0]; end
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = 64'(sp); mHi = up[63:32]; mLo = up[31:0];
            end
            2'b10: if (b != 0) begin mLo = a / b; mHi = a % b; end
            default: if (b != 0) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = sa / sb; r = sa % sb;
                mLo = 32'(q); mHi = 32'(r);
            end
        endcase
    endfunction

    initial begin
        int cyc;
        logic expEarly;
`ifdef MDU_BUSY_EARLY_EN
        expEarly = 1'b1;
`else
        expEarly = 1'b0;
`endif
        reset = 1'b1; start = 0; op = 0; write = 0; addr = 0; cancel = 0;
        rs_data = 0; rt_data = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);

        vecs[0] = '{3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N};
        vecs[1] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N};
        vecs[2] = '{3'b011, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
        vecs[3] = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_N};
        vecs[4] = '{3'b010, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_N};
        vecs[5] = '{3'b101, 32'd6,         32'd7,         32'd0,         32'd42,        MULT_N};

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].o, vecs[i].a, vecs[i].b, 1'b0, 0, 0, cyc);
            checkOutput($sformatf("vec%0d start-cycle busy", i), 32'(startBusy), 32'(expEarly));
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(cyc), 32'(vecs[i].expCycles));
            checkOutput($sformatf("vec%0d hi", i), hi, vecs[i].expHi);
            checkOutput($sformatf("vec%0d lo", i), lo, vecs[i].expLo);
            addr = 1'b1; #1;
            checkOutput($sformatf("vec%0d rdata lo", i), rdata, vecs[i].expLo);
            addr = 1'b0; #1;
            checkOutput($sformatf("vec%0d rdata hi", i), rdata, vecs[i].expHi);
        end

        // Divide by zero leaves HI/LO alone but still takes the full latency
        writeReg(1'b0, 32'h11);
        writeReg(1'b1, 32'h22);
        applyStimulus(3'b010, 32'd7, 32'd0, 1'b0, 0, 0, cyc);
        checkOutput("div0 cycles", 32'(cyc), 32'(DIV_N));
        checkOutput("div0 hi", hi, 32'h11);
        checkOutput("div0 lo", lo, 32'h22);

        // MTLO visible on rdata next cycle
        writeReg(1'b1, 32'hDEAD_BEEF);
        addr = 1'b1; #1;
        checkOutput("mtlo rdata", rdata, 32'hDEAD_BEEF);

        // MTHI during RUN is ignored
        applyStimulus(3'b001, 32'd6, 32'd7, 1'b0, 0, 2, cyc);
        checkOutput("mt-in-run hi", hi, 32'd0);
        checkOutput("mt-in-run lo", lo, 32'd42);

        // start + write together: start wins, HI untouched at launch
        writeReg(1'b0, 32'h1234);
        applyStimulus(3'b000, 32'd2, 32'd3, 1'b1, 0, 0, cyc);
        checkOutput("start+write hi at launch", snapHi, 32'h1234);
        checkOutput("start+write hi", hi, 32'd0);
        checkOutput("start+write lo", lo, 32'd6);

        // start with cancel does nothing
        writeReg(1'b0, 32'h11);
        writeReg(1'b1, 32'h22);
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'b001; rs_data = 32'd5; rt_data = 32'd5;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        checkOutput("cancel busy", 32'(busy), 32'd0);
        repeat (MULT_N + 1) @(negedge clk);
        checkOutput("cancel busy later", 32'(busy), 32'd0);
        checkOutput("cancel hi", hi, 32'h11);
        checkOutput("cancel lo", lo, 32'h22);

        // cancel mid-run does not disturb the op in flight
        applyStimulus(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0, 2, 0, cyc);
        checkOutput("midcancel cycles", 32'(cyc), 32'(DIV_N));
        checkOutput("midcancel hi", hi, 32'hFFFF_FFFF);
        checkOutput("midcancel lo", lo, 32'hFFFF_FFFD);

        // reset in the middle of a DIV
        writeReg(1'b0, 32'hAA);
        writeReg(1'b1, 32'hBB);
        @(negedge clk);
        start = 1'b1; op = 3'b011; rs_data = 32'd100; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset hi", hi, 32'd0);
        checkOutput("midreset lo", lo, 32'd0);
        applyStimulus(3'b001, 32'd6, 32'd7, 1'b0, 0, 0, cyc);
        checkOutput("post-reset cycles", 32'(cyc), 32'(MULT_N));
        checkOutput("post-reset lo", lo, 32'd42);

        // Randomized ops against the reference model
        mHi = $urandom; mLo = $urandom;
        writeReg(1'b0, mHi);
        writeReg(1'b1, mLo);
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            if ($urandom_range(0, 4) == 0) begin
                ra = $urandom;
                if ($urandom_range(0, 1) == 1) begin writeReg(1'b1, ra); mLo = ra; end
                else begin writeReg(1'b0, ra); mHi = ra; end
            end else begin
                ro = 3'($urandom);
                ra = $urandom;
                rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
                modelOp(ro, ra, rb);
                applyStimulus(ro, ra, rb, 1'b0, 0, 0, cyc);
                checkOutput($sformatf("rnd%0d cycles", i), 32'(cyc), 32'(ro[1] ? DIV_N : MULT_N));
            end
            checkOutput($sformatf("rnd%0d hi", i), hi, mHi);
            checkOutput($sformatf("rnd%0d lo", i), lo, mLo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
